// File: rtl/mc_decode_ext.sv
// mc_decode_ext: multicycle ARM-subset control decoder.
// Contains the Moore main FSM, the ALU decoder, the PC-write logic and the
// instruction decoder. It also decodes EOR/MOV/CMP, runs a multi-cycle MUL
// execute state with a latency counter, and pulses Undef on an undefined Op.
//
// Build option: define MC_DECODE_BL_EN to build branch-with-link (LINK state).
//
// Parameters:
//   ALUCTRL_W  ALUControl width (>= 3); bits above [2] are driven 0.
//   MUL_LAT    number of cycles spent in MULEXEC (>= 1).
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   Op, Funct, Rd, Instr74     latched instruction fields
//   PCS, NextPC, RegW, MemW    write strobes to condlogic (unconditioned)
//   IRWrite, AdrSrc            datapath controls
//   ResultSrc, ALUSrcA/B       datapath mux selects
//   ALUControl, FlagW          ALU operation and flag-write enables
//   ImmSrc, RegSrc             instruction decoder outputs
//   LinkW                      RegW targets R14
//   Undef                      one-cycle pulse in DECODE on Op=11
//   StateDbg                   current state encoding
module mc_decode_ext #(
  parameter int ALUCTRL_W = 3,
  parameter int MUL_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Instr74,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 LinkW,
  output logic                 Undef,
  output logic [3:0]           StateDbg
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_MULEXEC  = 4'd10
`ifdef MC_DECODE_BL_EN
    , S_LINK   = 4'd11
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       is_mul;
  logic       branch;
  logic       dec_en;
  logic       cmd_known;
  logic       is_cmp;
  logic [2:0] alu3;

  assign is_mul = (Op == 2'b00) && (Funct[5:4] == 2'b00) && (Instr74 == 4'b1001);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, MUL latency counter and Undef pulse.
  always_comb begin
    state_d = S_FETCH;
    cnt_d   = '0;
    Undef   = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01: state_d = S_MEMADR;
          2'b00: begin
            if (is_mul)        state_d = S_MULEXEC;
            else if (Funct[5]) state_d = S_EXECUTEI;
            else               state_d = S_EXECUTER;
          end
          2'b10: begin
`ifdef MC_DECODE_BL_EN
            state_d = Funct[4] ? S_LINK : S_BRANCH;
`else
            state_d = S_BRANCH;
`endif
          end
          default: begin
            state_d = S_FETCH;
            Undef   = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_MULEXEC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_MULEXEC;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef MC_DECODE_BL_EN
      S_LINK:     state_d = S_BRANCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // ALU decoder. Enabled in the execute states and also in ALUWB: the
  // instruction fields are still latched there, so ALUControl/FlagW keep
  // their execute-cycle values. Decoding from state directly (instead of a
  // separate ALUOp strobe) keeps the RegW dependency free of loops.
  assign dec_en = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI) ||
                  (state_q == S_MULEXEC)  || (state_q == S_ALUWB);

  always_comb begin
    alu3      = 3'b000;
    FlagW     = 2'b00;
    cmd_known = 1'b0;
    is_cmp    = 1'b0;
    if (dec_en) begin
      if (is_mul) begin
        alu3      = 3'b110;
        cmd_known = 1'b1;
        FlagW     = {Funct[0], 1'b0};
      end else begin
        cmd_known = 1'b1;
        case (Funct[4:1])
          4'b0100: alu3 = 3'b000;                    // ADD
          4'b0010: alu3 = 3'b001;                    // SUB
          4'b1010: begin alu3 = 3'b001; is_cmp = 1'b1; end
          4'b0000: alu3 = 3'b010;                    // AND
          4'b1100: alu3 = 3'b011;                    // ORR
          4'b0001: alu3 = 3'b100;                    // EOR
          4'b1101: alu3 = 3'b101;                    // MOV
          default: cmd_known = 1'b0;
        endcase
        if (is_cmp) begin
          FlagW = 2'b11;
        end else if (cmd_known) begin
          FlagW[1] = Funct[0];
          FlagW[0] = Funct[0] & ((Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010));
        end
      end
    end
  end

  assign ALUControl = ALUCTRL_W'(alu3);

  // Per-state Moore outputs.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    MemW      = 1'b0;
    RegW      = 1'b0;
    LinkW     = 1'b0;
    branch    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTEI: ALUSrcB = 2'b01;
      S_ALUWB:    RegW    = cmd_known & ~is_cmp;
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
`ifdef MC_DECODE_BL_EN
      S_LINK: begin
        RegW      = 1'b1;
        LinkW     = 1'b1;
        ResultSrc = 2'b11;
      end
`endif
      default: ;
    endcase
  end

  assign PCS      = ((Rd == 4'b1111) & RegW & ~LinkW) | branch;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign StateDbg = state_q;

endmodule

// File: tb/tb_mc_decode_ext.sv
module tb_mc_decode_ext;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic [3:0] Instr74 = '0;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, LinkW, Undef;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, FlagW, ImmSrc, RegSrc;
  logic [3:0] ALUControl;
  logic [3:0] StateDbg;

  mc_decode_ext #(.ALUCTRL_W(4), .MUL_LAT(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Instr74(Instr74),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .FlagW(FlagW), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .LinkW(LinkW), .Undef(Undef), .StateDbg(StateDbg)
  );

  always #5 clk = ~clk;

  // Observed outputs packed in the same order as e() below.
  logic [27:0] obs;
  assign obs = {StateDbg, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, FlagW, Undef, LinkW, ImmSrc, RegSrc};

  typedef struct {
    logic        rst;
    logic [15:0] ins;   // {Op, Funct, Rd, Instr74}
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // strb = {PCS, NextPC, RegW, MemW, IRWrite, AdrSrc}
  function automatic logic [27:0] e(input logic [3:0] st, input logic [5:0] strb,
                                    input logic [1:0] res, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [3:0] alu,
                                    input logic [1:0] fw, input logic u, input logic l,
                                    input logic [1:0] imm, input logic [1:0] rs);
    return {st, strb, res, sa, sb, alu, fw, u, l, imm, rs};
  endfunction

  task automatic add(input logic r, input logic [15:0] ins, input logic [27:0] ex);
    vec_t v;
    v.rst = r; v.ins = ins; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, ex);
    end
  endtask

  task automatic tick(input logic r, input logic [15:0] ins);
    @(negedge clk);
    reset = r;
    {Op, Funct, Rd, Instr74} = ins;
    #1;
  endtask

  localparam logic [15:0] I_RST  = {2'b00, 6'b000000, 4'h0, 4'h0};
  localparam logic [15:0] I_ADDS = {2'b00, 6'b001001, 4'h2, 4'h0};
  localparam logic [15:0] I_CMP  = {2'b00, 6'b010101, 4'hF, 4'h0};
  localparam logic [15:0] I_ORRI = {2'b00, 6'b111000, 4'h3, 4'h0};
  localparam logic [15:0] I_EORS = {2'b00, 6'b000011, 4'hF, 4'h0};
  localparam logic [15:0] I_UNK  = {2'b00, 6'b000110, 4'h5, 4'h0};
  localparam logic [15:0] I_MULS = {2'b00, 6'b000001, 4'h4, 4'b1001};
  localparam logic [15:0] I_LDR  = {2'b01, 6'b011001, 4'hF, 4'h0};
  localparam logic [15:0] I_STR  = {2'b01, 6'b011000, 4'h1, 4'h0};
  localparam logic [15:0] I_UND  = {2'b11, 6'b000000, 4'h0, 4'h0};
  localparam logic [15:0] I_BL   = {2'b10, 6'b010000, 4'hF, 4'h0};

  logic [27:0] F00, D00, F01, D01, F11, F10, D10;
  int n10;
  logic [3:0] tgt;

  initial begin
    F00 = e(4'd0, 6'b010010, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    D00 = e(4'd1, 6'b000000, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    F01 = e(4'd0, 6'b010010, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10);
    D01 = e(4'd1, 6'b000000, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10);
    F11 = e(4'd0, 6'b010010, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);
    F10 = e(4'd0, 6'b010010, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b01);
    D10 = e(4'd1, 6'b000000, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b01);

    // Reset held two cycles
    add(1, I_RST, F00);
    add(1, I_RST, F00);
    // ADDS register
    add(0, I_ADDS, F00);
    add(0, I_ADDS, D00);
    add(0, I_ADDS, e(4'd6, 6'b000000, 2'b00, 2'b00, 2'b00, 4'h0, 2'b11, 0, 0, 2'b00, 2'b00));
    add(0, I_ADDS, e(4'd8, 6'b001000, 2'b00, 2'b00, 2'b00, 4'h0, 2'b11, 0, 0, 2'b00, 2'b00));
    // CMP with Rd=15: no write, no PC write
    add(0, I_CMP, F00);
    add(0, I_CMP, D00);
    add(0, I_CMP, e(4'd6, 6'b000000, 2'b00, 2'b00, 2'b00, 4'h1, 2'b11, 0, 0, 2'b00, 2'b00));
    add(0, I_CMP, e(4'd8, 6'b000000, 2'b00, 2'b00, 2'b00, 4'h1, 2'b11, 0, 0, 2'b00, 2'b00));
    // ORR immediate, no S
    add(0, I_ORRI, F00);
    add(0, I_ORRI, D00);
    add(0, I_ORRI, e(4'd7, 6'b000000, 2'b00, 2'b00, 2'b01, 4'h3, 2'b00, 0, 0, 2'b00, 2'b00));
    add(0, I_ORRI, e(4'd8, 6'b001000, 2'b00, 2'b00, 2'b00, 4'h3, 2'b00, 0, 0, 2'b00, 2'b00));
    // EORS to R15: PCS from ALUWB
    add(0, I_EORS, F00);
    add(0, I_EORS, D00);
    add(0, I_EORS, e(4'd6, 6'b000000, 2'b00, 2'b00, 2'b00, 4'h4, 2'b10, 0, 0, 2'b00, 2'b00));
    add(0, I_EORS, e(4'd8, 6'b101000, 2'b00, 2'b00, 2'b00, 4'h4, 2'b10, 0, 0, 2'b00, 2'b00));
    // Unknown command: RegW suppressed
    add(0, I_UNK, F00);
    add(0, I_UNK, D00);
    add(0, I_UNK, e(4'd6, 6'b000000, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0, 0, 2'b00, 2'b00));
    add(0, I_UNK, e(4'd8, 6'b000000, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0, 0, 2'b00, 2'b00));
    // MULS: four MULEXEC cycles, 7 cycles total
    add(0, I_MULS, F00);
    add(0, I_MULS, D00);
    for (int i = 0; i < 4; i++)
      add(0, I_MULS, e(4'd10, 6'b000000, 2'b00, 2'b00, 2'b00, 4'h6, 2'b10, 0, 0, 2'b00, 2'b00));
    add(0, I_MULS, e(4'd8, 6'b001000, 2'b00, 2'b00, 2'b00, 4'h6, 2'b10, 0, 0, 2'b00, 2'b00));
    // LDR to R15
    add(0, I_LDR, F01);
    add(0, I_LDR, D01);
    add(0, I_LDR, e(4'd2, 6'b000000, 2'b00, 2'b00, 2'b01, 4'h0, 2'b00, 0, 0, 2'b01, 2'b10));
    add(0, I_LDR, e(4'd3, 6'b000001, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0, 0, 2'b01, 2'b10));
    add(0, I_LDR, e(4'd4, 6'b101000, 2'b01, 2'b00, 2'b00, 4'h0, 2'b00, 0, 0, 2'b01, 2'b10));
    // STR
    add(0, I_STR, F01);
    add(0, I_STR, D01);
    add(0, I_STR, e(4'd2, 6'b000000, 2'b00, 2'b00, 2'b01, 4'h0, 2'b00, 0, 0, 2'b01, 2'b10));
    add(0, I_STR, e(4'd5, 6'b000101, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0, 0, 2'b01, 2'b10));
    // Undefined Op: one Undef pulse in DECODE, back to FETCH
    add(0, I_UND, F11);
    add(0, I_UND, e(4'd1, 6'b000000, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 1, 0, 2'b11, 2'b00));
    add(0, I_UND, F11);
    // Branch (with link when built)
    add(0, I_BL, D10);
`ifdef MC_DECODE_BL_EN
    add(0, I_BL, e(4'd11, 6'b001000, 2'b11, 2'b00, 2'b00, 4'h0, 2'b00, 0, 1, 2'b10, 2'b01));
`endif
    add(0, I_BL, e(4'd9, 6'b100000, 2'b10, 2'b10, 2'b01, 4'h0, 2'b00, 0, 0, 2'b10, 2'b01));
    add(0, I_BL, F10);

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].ins);
      chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
    end

    // Reset in the middle of MULEXEC: async return to FETCH, counter cleared
    tick(1, I_MULS);
    tick(0, I_MULS);
    chk("mr_fetch", 32'(StateDbg), 32'd0);
    tick(0, I_MULS);
    chk("mr_decode", 32'(StateDbg), 32'd1);
    tick(0, I_MULS);
    tick(0, I_MULS);
    chk("mr_mul2", 32'(StateDbg), 32'd10);
    #2 reset = 1'b1;
    #1;
    chk("mr_async", 32'(StateDbg), 32'd0);
    chk("mr_irw_npc", 32'({IRWrite, NextPC}), 32'd3);
    tick(0, I_MULS);
    chk("mr_fetch2", 32'(StateDbg), 32'd0);
    tick(0, I_MULS);
    chk("mr_decode2", 32'(StateDbg), 32'd1);
    n10 = 0;
    tick(0, I_MULS);
    while (StateDbg == 4'd10 && n10 < 20) begin
      n10++;
      tick(0, I_MULS);
    end
    chk("mr_mul_cycles", 32'(n10), 32'd4);
    chk("mr_aluwb", 32'(StateDbg), 32'd8);

    // Reset while in LINK (or BRANCH without link support)
`ifdef MC_DECODE_BL_EN
    tgt = 4'd11;
`else
    tgt = 4'd9;
`endif
    tick(1, I_BL);
    tick(0, I_BL);
    tick(0, I_BL);
    tick(0, I_BL);
    chk("lr_state", 32'(StateDbg), 32'(tgt));
    #2 reset = 1'b1;
    #1;
    chk("lr_async", 32'(StateDbg), 32'd0);
    chk("lr_linkw", 32'(LinkW), 32'd0);
    tick(0, I_BL);
    chk("lr_fetch", 32'(StateDbg), 32'd0);
    tick(0, I_BL);
    chk("lr_decode", 32'(StateDbg), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
